// File: rtl/lifo_stack.sv
// Parametrised LIFO stack. The top entry is always visible on data_out, and count
// doubles as the write pointer. Push and pop together replace the top entry.
module lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_nxt;
    logic [CW-1:0]    wr_idx;
    logic             wr_en;
    logic             ovf_nxt;
    logic             udf_nxt;
    logic             set_ovf;
    logic             set_udf;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    always_comb begin
        count_nxt = count;
        wr_idx    = count;
        wr_en     = 1'b0;
        set_ovf   = 1'b0;
        set_udf   = 1'b0;
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = count - 1'b1;
        end else if (push) begin
            // push+pop on an empty stack falls through here as a plain push
            if (!full) begin
                wr_en     = 1'b1;
                count_nxt = count + 1'b1;
            end else begin
                set_ovf = 1'b1;
            end
        end else if (pop) begin
            if (!empty) count_nxt = count - 1'b1;
            else        set_udf   = 1'b1;
        end
        ovf_nxt = (overflow  & ~err_clr) | set_ovf;
        udf_nxt = (underflow & ~err_clr) | set_udf;
        if (clr) begin
            count_nxt = '0;
            wr_en     = 1'b0;
            ovf_nxt   = 1'b0;
            udf_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            overflow  <= ovf_nxt;
            underflow <= udf_nxt;
        end
    end

    // Storage is deliberately not reset; only count defines validity.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk) begin
            if (wr_en && wr_idx == CW'(i)) mem[i] <= data_in;
        end
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count == CW'(i + 1)) data_out = mem[i];
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack: a queue-based model checked every cycle,
// plus literal expectations taken from the hand-worked scenarios.
module tb_lifo_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             empty, full, overflow, underflow;

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .pop(pop),
        .err_clr(err_clr), .data_in(data_in), .data_out(data_out),
        .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Model: a queue whose back is the top of stack
    logic [WIDTH-1:0] q[$];
    bit m_ovf, m_udf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (clr) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            bit eo, eu;
            eo = 1'b0;
            eu = 1'b0;
            if (push && pop && q.size() > 0) q[q.size()-1] = data_in;
            else if (push) begin
                if (q.size() < DEPTH) q.push_back(data_in);
                else eo = 1'b1;
            end else if (pop) begin
                if (q.size() > 0) void'(q.pop_back());
                else eu = 1'b1;
            end
            if (err_clr) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            m_ovf = m_ovf | eo;
            m_udf = m_udf | eu;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_count", int'(count), q.size());
            chk("m_data_out", int'(data_out), q.size() > 0 ? int'(q[q.size()-1]) : 0);
            chk("m_empty", int'(empty), int'(q.size() == 0));
            chk("m_full", int'(full), int'(q.size() == DEPTH));
            chk("m_overflow", int'(overflow), int'(m_ovf));
            chk("m_underflow", int'(underflow), int'(m_udf));
        end
    end

    // Applies one operation across a single rising edge, then idles the inputs
    task automatic op(input bit c, input bit pu, input bit po, input bit ec, input int d);
        @(negedge clk);
        clr = c; push = pu; pop = po; err_clr = ec; data_in = WIDTH'(d);
        @(posedge clk);
        #1;
        clr = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; data_in = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_udf"}, int'(underflow), 0);
        chk({tag, "_dout"}, int'(data_out), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // basic push/pop
        op(0, 1, 0, 0, 31);
        op(0, 1, 0, 0, 1023 & 8'hFF);
        chk("two_count", int'(count), 2);
        chk("two_dout", int'(data_out), 8'hFF);
        op(0, 0, 1, 0, 0);
        chk("pop1_dout", int'(data_out), 31);
        chk("pop1_count", int'(count), 1);
        op(0, 0, 1, 0, 0);
        chk("pop2_empty", int'(empty), 1);
        chk("pop2_dout", int'(data_out), 0);

        // fill, overflow, drain
        for (int i = 1; i <= 8; i++) op(0, 1, 0, 0, i);
        chk("fill_full", int'(full), 1);
        chk("fill_dout", int'(data_out), 8);
        op(0, 1, 0, 0, 9);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_count", int'(count), 8);
        chk("ovf_dout", int'(data_out), 8);
        for (int i = 1; i <= 8; i++) begin
            op(0, 0, 1, 0, 0);
            if (i < 8) chk("drain_dout", int'(data_out), 8 - i);
        end
        chk("drain_empty", int'(empty), 1);
        chk("drain_ovf_sticky", int'(overflow), 1);

        // underflow and err_clr
        op(0, 0, 1, 0, 0);
        chk("udf_flag", int'(underflow), 1);
        chk("udf_count", int'(count), 0);
        op(0, 0, 0, 1, 0);
        chk("errclr_ovf", int'(overflow), 0);
        chk("errclr_udf", int'(underflow), 0);
        op(0, 0, 1, 1, 0);
        chk("errclr_new_wins", int'(underflow), 1);
        op(0, 0, 0, 1, 0);

        // replace
        op(0, 1, 0, 0, 5);
        op(0, 1, 1, 0, 9);
        chk("repl_dout", int'(data_out), 9);
        chk("repl_count", int'(count), 1);
        for (int i = 2; i <= 8; i++) op(0, 1, 0, 0, i);
        op(0, 1, 1, 0, 8'hAA);
        chk("repl_full_dout", int'(data_out), 8'hAA);
        chk("repl_full_full", int'(full), 1);
        chk("repl_full_ovf", int'(overflow), 0);
        op(1, 0, 0, 0, 0);
        op(0, 1, 1, 0, 3);
        chk("repl_empty_count", int'(count), 1);
        chk("repl_empty_dout", int'(data_out), 3);
        chk("repl_empty_udf", int'(underflow), 0);

        // clr beats push
        op(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) op(0, 1, 0, 0, 8'h40 + i);
        chk("clr_pre_ovf", int'(overflow), 1);
        op(1, 1, 0, 0, 8'h77);
        chk("clr_count", int'(count), 0);
        chk("clr_empty", int'(empty), 1);
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_udf", int'(underflow), 0);
        chk("clr_dout", int'(data_out), 0);

        // asynchronous reset between edges
        for (int i = 0; i < 4; i++) op(0, 1, 0, 0, 8'h20 + i);
        chk("pre_rst_count", int'(count), 4);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        op(0, 1, 0, 0, 8'h11);
        chk("post_rst_dout", int'(data_out), 8'h11);
        chk("post_rst_count", int'(count), 1);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
